uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
- Parametrised UART receive path: 2-flop input synchroniser, start-bit validation, mid-bit sampling, LSB-first data shift and stop-bit check.
- Delivers one data word per good frame with a single-cycle valid strobe. Flags framing errors.
- Successor to the fixed-wait start-bit counter. Sits between the uart_rx pin and the RX consumer logic.

Parameters:
- CLKS_PER_BIT, 234, clk cycles per UART bit; must be >= 4 (elaboration-time check).
- DATA_BITS, 8, data bits per frame, 5..9.
- STOP_BITS, 1, stop bits checked per frame, 1 or 2.
- PARITY_ODD, 0, used only with UART_RX_PARITY_EN; 0 = even parity, 1 = odd parity.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- uart_rx  in  1  asynchronous serial line; idle high.
- rx_data  out  DATA_BITS  last good word; bit 0 is the first received bit.
- rx_valid  out  1  one-cycle strobe; rx_data updated in the same cycle.
- rx_frame_err  out  1  one-cycle strobe on a bad stop bit.
- rx_busy  out  1  high whenever FSM is not IDLE.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - rx_data=0, rx_valid=0, rx_frame_err=0, rx_busy=0.
  - FSM=IDLE, counters=0.
  - Both synchroniser flops=1, so no false start after reset.
- Reset mid-frame: abandons the frame with no strobe. Reset has priority over all events.
- Synchroniser: rs is the output of the second flop. If uart_rx first goes low before edge A, rs=0 is seen by the FSM at edge E0=A+2.
- HALF = CLKS_PER_BIT/2 (integer division). Counter width is $clog2(CLKS_PER_BIT).
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: at an edge with rs=0 (edge E0) -> START, cnt=0.
  - START: cnt increments each edge. At the edge where cnt==HALF-1 (edge E0+HALF):
    - rs=0 -> DATA, cnt=0, bit index=0.
    - rs=1 -> IDLE (glitch rejected; no strobe).
  - DATA: cnt counts 0..CLKS_PER_BIT-1 and wraps to 0. At each wrap, sample rs into the shift register MSB and shift right (LSB-first).
    - Bit i is sampled at edge E0+HALF+(i+1)*CLKS_PER_BIT.
    - After DATA_BITS samples -> STOP.
  - STOP: same bit timing as DATA. Samples STOP_BITS stop bits; any stop sample of 0 marks the frame bad. At the final stop sample:
    - Good frame: rx_data <= shift register, rx_valid=1 for one cycle, -> IDLE.
    - Bad frame: rx_frame_err=1 for one cycle, rx_data unchanged, -> WAIT_IDLE.
  - WAIT_IDLE: stay until rs=1, then -> IDLE. This prevents re-triggering on a break or stuck-low line.
- Latency, 8N1 with CLKS_PER_BIT=8: rx_valid is high in the cycle after edge A+2+4+72=A+78.
- Back-to-back frames: the FSM returns to IDLE half a bit before the stop bit ends, so a start bit immediately following the stop bit is captured.
- rx_valid and rx_frame_err are never high in the same cycle.
- No backpressure: the consumer must take rx_data on rx_valid. rx_data is held until the next good frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state after DATA that samples one parity bit; the stop-bit timing shifts by one bit time.
  - Adds output port rx_parity_err, 1 bit, reset 0.
  - Parity is checked with PARITY_ODD. On mismatch with a good stop bit: rx_parity_err pulses for one cycle in place of rx_valid, rx_data is not updated, FSM -> IDLE.
  - A framing error takes precedence: rx_frame_err only.
- Undefined: no PARITY state, no rx_parity_err port; the frame is start + data + stop only.

Test Plan:
All scenarios use CLKS_PER_BIT=8, DATA_BITS=8, STOP_BITS=1; A = first edge after uart_rx goes low.
1. Reset, then hold uart_rx=1 for 20 cycles -> all outputs 0, rx_busy=0 throughout.
2. Send 0xA5 8N1 with an 8-clk bit time -> rx_valid high for exactly one cycle, after edge A+78; rx_data=0xA5; rx_frame_err stays 0.
3. Drive uart_rx low for 2 cycles, then high -> rx_busy high for about 4 cycles, then 0; no rx_valid and no rx_frame_err.
4. Send 0x3C with stop bit 0 and hold the line low 30 more cycles -> one rx_frame_err pulse; rx_data stays 0xA5; rx_busy stays 1 until the line returns to 1.
5. Send 0x00 then 0xFF with no idle gap -> two rx_valid pulses 80 cycles apart, with rx_data 0x00 then 0xFF.
6. Assert rst during data bit 3, release it, then send 0x5A -> outputs are 0 the cycle after rst; next rx_valid carries 0x5A with no error strobe.

Source files
------------

// File: rtl/uart_rx_frame.sv
// UART receive frame: synchroniser, start validation, mid-bit sampling, stop check.
// Optional parity bit and rx_parity_err port when UART_RX_PARITY_EN is defined.
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 234,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 rx_parity_err,
`endif
    output logic                 rx_busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] C_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    B_DLST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    B_SLST = 4'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_chk_cpb
        $error("CLKS_PER_BIT must be >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_db
        $error("DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_sb
        $error("STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_chk_po
        $error("PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_nxt;
    logic [3:0]           r_bit;
    logic [3:0]           w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 r_bad;
    logic                 w_bad_nxt;
    logic                 w_stop_bad;
    logic [DATA_BITS-1:0] r_data;
    logic [DATA_BITS-1:0] w_data_nxt;
    logic                 r_valid;
    logic                 w_valid_nxt;
    logic                 r_ferr;
    logic                 w_ferr_nxt;
    logic                 w_rs;
    logic                 w_wrap;
`ifdef UART_RX_PARITY_EN
    logic                 r_par;
    logic                 w_par_nxt;
    logic                 r_perr;
    logic                 w_perr_nxt;
    logic                 w_par_bad;
`endif

    assign w_rs   = r_sync2;
    assign w_wrap = (r_cnt == C_LAST);

`ifdef UART_RX_PARITY_EN
    assign w_par_bad     = r_par ^ 1'(PARITY_ODD);
    assign rx_parity_err = r_perr;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_bad_nxt   = r_bad;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        w_stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_nxt   = r_par;
        w_perr_nxt  = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rs) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cnt == C_HALF) begin
                    w_cnt_nxt = '0;
                    w_bit_nxt = '0;
                    w_state_nxt = w_rs ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
                    w_par_nxt = 1'b0;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (w_wrap) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rs, r_shift[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
                    w_par_nxt   = r_par ^ w_rs;
`endif
                    if (r_bit == B_DLST) begin
                        w_bit_nxt = '0;
                        w_bad_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit + 4'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_wrap) begin
                    w_cnt_nxt   = '0;
                    w_par_nxt   = r_par ^ w_rs;
                    w_state_nxt = S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
`endif
            S_STOP: begin
                w_stop_bad = r_bad | ~w_rs;
                if (w_wrap) begin
                    w_cnt_nxt = '0;
                    w_bad_nxt = w_stop_bad;
                    if (r_bit != B_SLST) begin
                        w_bit_nxt = r_bit + 4'd1;
                    end else if (w_stop_bad) begin
                        // Line may be held low (break); wait for idle before re-arming
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (w_par_bad) begin
                        w_perr_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
`endif
                    else begin
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = r_shift;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_WAIT: begin
                w_cnt_nxt = '0;
                if (w_rs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_bad   <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_bad   <= w_bad_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
            r_par   <= w_par_nxt;
            r_perr  <= w_perr_nxt;
`endif
        end
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_ferr;
    assign rx_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed scenarios, a vector table and random
// frames checked against expected word/strobe timing computed from the frame format.
module tb_uart_rx_frame;

    localparam int CPB = 8;
    localparam int DB  = 8;
    localparam int SB  = 1;
    // Edge of the last stop-bit sample, counted from edge A
    localparam int LAT = 2 + CPB / 2 + (DB + SB) * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       rx_parity_err;
`endif

    uart_rx_frame #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS(DB),
        .STOP_BITS(SB),
        .PARITY_ODD(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .uart_rx(uart_rx),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_frame_err(rx_frame_err),
`ifdef UART_RX_PARITY_EN
        .rx_parity_err(rx_parity_err),
`endif
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int overlap = 0;
    int         vtime[$];
    logic [7:0] vdata[$];
    int         etime[$];

    always @(negedge clk) begin
        if (rx_valid) begin
            vtime.push_back(cyc);
            vdata.push_back(rx_data);
        end
        if (rx_frame_err) etime.push_back(cyc);
        if (rx_valid && rx_frame_err) overlap++;
    end

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         gap;
        int         exp_v;
        int         exp_e;
        logic [7:0] exp_d;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        vtime.delete();
        vdata.delete();
        etime.delete();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              output int a);
        a = cyc + 1;
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < DB; i++) begin
            uart_rx = d[i];
            tick(CPB);
        end
        uart_rx = stop;
        tick(CPB);
    endtask

    initial begin
        int a, a2, bad, nb;
        int         ex_vt[$];
        logic [7:0] ex_vd[$];
        int         ex_et[$];
        logic [7:0] last_good;
        logic [7:0] d;
        logic [7:0] pat;

        tbl[0] = '{8'h01, 1'b1, 3,  1, 0, 8'h01};
        tbl[1] = '{8'h80, 1'b1, 0,  1, 0, 8'h80};
        tbl[2] = '{8'hC3, 1'b0, 5,  0, 1, 8'h80};
        tbl[3] = '{8'h7E, 1'b1, 2,  1, 0, 8'h7E};
        tbl[4] = '{8'h00, 1'b0, 12, 0, 1, 8'h7E};
        tbl[5] = '{8'h55, 1'b1, 1,  1, 0, 8'h55};

        rst = 1'b1;
        uart_rx = 1'b1;
        tick(3);
        chk("rst_data", rx_data, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_ferr", rx_frame_err, 0);
        chk("rst_busy", rx_busy, 0);
        rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (rx_busy || rx_valid || rx_frame_err || rx_data != 8'h00) bad++;
        end
        chk("idle_quiet", bad, 0);

        clr();
        send_frame(8'hA5, 1'b1, a);
        tick(4);
        chk("a5_nvalid", vtime.size(), 1);
        if (vtime.size() >= 1) begin
            chk("a5_time", vtime[0], a + LAT);
            chk("a5_data", vdata[0], 8'hA5);
        end
        chk("a5_nerr", etime.size(), 0);
        chk("a5_hold", rx_data, 8'hA5);

        clr();
        uart_rx = 1'b0;
        tick(2);
        uart_rx = 1'b1;
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (rx_busy) nb++;
        end
        chk("glitch_busy", nb, 4);
        chk("glitch_nvalid", vtime.size(), 0);
        chk("glitch_nerr", etime.size(), 0);

        clr();
        send_frame(8'h3C, 1'b0, a);
        tick(30);
        chk("ferr_nerr", etime.size(), 1);
        if (etime.size() >= 1) chk("ferr_time", etime[0], a + LAT);
        chk("ferr_nvalid", vtime.size(), 0);
        chk("ferr_data", rx_data, 8'hA5);
        chk("ferr_busy_low", rx_busy, 1);
        uart_rx = 1'b1;
        tick(4);
        chk("ferr_busy_rel", rx_busy, 0);

        clr();
        send_frame(8'h00, 1'b1, a);
        send_frame(8'hFF, 1'b1, a2);
        tick(4);
        chk("b2b_nvalid", vtime.size(), 2);
        if (vtime.size() == 2) begin
            chk("b2b_t0", vtime[0], a + LAT);
            chk("b2b_t1", vtime[1], a2 + LAT);
            chk("b2b_gap", vtime[1] - vtime[0], 80);
            chk("b2b_d0", vdata[0], 8'h00);
            chk("b2b_d1", vdata[1], 8'hFF);
        end
        chk("b2b_nerr", etime.size(), 0);

        clr();
        pat = 8'h96;
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            uart_rx = pat[i];
            tick(CPB);
        end
        uart_rx = pat[3];
        tick(CPB / 2);
        rst = 1'b1;
        tick(1);
        chk("mrst_data", rx_data, 0);
        chk("mrst_valid", rx_valid, 0);
        chk("mrst_ferr", rx_frame_err, 0);
        chk("mrst_busy", rx_busy, 0);
        rst = 1'b0;
        uart_rx = 1'b1;
        tick(4);
        chk("mrst_nstrobe", vtime.size() + etime.size(), 0);
        clr();
        send_frame(8'h5A, 1'b1, a);
        tick(4);
        chk("mrst_nvalid", vtime.size(), 1);
        if (vtime.size() >= 1) begin
            chk("mrst_time", vtime[0], a + LAT);
            chk("mrst_d", vdata[0], 8'h5A);
        end
        chk("mrst_nerr", etime.size(), 0);

        for (int i = 0; i < 6; i++) begin
            clr();
            send_frame(tbl[i].d, tbl[i].stop, a);
            tick(tbl[i].gap);
            uart_rx = 1'b1;
            tick(4);
            chk($sformatf("tbl%0d_nvalid", i), vtime.size(), tbl[i].exp_v);
            chk($sformatf("tbl%0d_nerr", i), etime.size(), tbl[i].exp_e);
            chk($sformatf("tbl%0d_data", i), rx_data, tbl[i].exp_d);
            if (tbl[i].exp_v == 1 && vtime.size() == 1)
                chk($sformatf("tbl%0d_time", i), vtime[0], a + LAT);
            if (tbl[i].exp_e == 1 && etime.size() == 1)
                chk($sformatf("tbl%0d_etime", i), etime[0], a + LAT);
        end

        clr();
        last_good = rx_data;
        for (int i = 0; i < 24; i++) begin
            int kind;
            kind = $urandom_range(0, 9);
            d = 8'($urandom);
            if (kind == 0) begin
                uart_rx = 1'b0;
                tick($urandom_range(1, 3));
                uart_rx = 1'b1;
                tick($urandom_range(6, 12));
            end else if (kind == 1) begin
                send_frame(d, 1'b0, a);
                ex_et.push_back(a + LAT);
                tick($urandom_range(0, 10));
                uart_rx = 1'b1;
                tick($urandom_range(3, 15));
            end else begin
                send_frame(d, 1'b1, a);
                ex_vt.push_back(a + LAT);
                ex_vd.push_back(d);
                last_good = d;
                tick($urandom_range(0, 15));
            end
        end
        uart_rx = 1'b1;
        tick(6);
        chk("rnd_nvalid", vtime.size(), ex_vt.size());
        chk("rnd_nerr", etime.size(), ex_et.size());
        if (vtime.size() == ex_vt.size()) begin
            for (int i = 0; i < ex_vt.size(); i++) begin
                chk($sformatf("rnd_vt%0d", i), vtime[i], ex_vt[i]);
                chk($sformatf("rnd_vd%0d", i), vdata[i], ex_vd[i]);
            end
        end
        if (etime.size() == ex_et.size()) begin
            for (int i = 0; i < ex_et.size(); i++)
                chk($sformatf("rnd_et%0d", i), etime[i], ex_et[i]);
        end
        chk("rnd_last", rx_data, last_good);
        chk("rnd_busy", rx_busy, 0);

        chk("no_overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
